imem_responder: RTL and testbench
=================================

# imem_responder

Responder end of the instruction-memory request/response interface (`mem_in_type` / `mem_out_type`). It accepts the fetch path's requests and returns 32-bit instruction words after a fixed, parameterised wait. It is backed by a word-organised on-chip RAM. It sits between the fetch stage's `imem_in`/`imem_out` ports and the memory array, and serves as both the simulation TCM and the FPGA instruction store.

## Interface
Parameters:
- `DEPTH`, 4096: array size in 32-bit words; power of two, ≥ 16.
- `LATENCY`, 1: extra wait cycles before `mem_ready`; 0..15.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `imem_in` input `mem_in_type`:
  - `mem_valid` (1): request.
  - `mem_instr` (1): instruction access.
  - `mem_addr` (32): byte address.
  - `mem_wdata` (32): write data.
  - `mem_wstrb` (4): byte write strobes.
- `imem_out` output `mem_out_type`:
  - `mem_rdata` (32): response data.
  - `mem_ready` (1): one-cycle response pulse.

## Operation
- FSM states `IDLE`, `WAIT`, `RESP`; reset state `IDLE`.
- Accept condition: `mem_valid=1` while in `IDLE` or `RESP`. Requests in `WAIT` are ignored; the initiator holds or re-presents them.
- On accept, the block latches the word index `mem_addr[log2(DEPTH)+1:2]`, `wstrb` and `wdata`, and loads the wait counter with `LATENCY`.
- After accept:
  - Counter ≠ 0 → `WAIT`.
  - Counter = 0 → `RESP` next cycle.
- `WAIT`: the counter decrements each cycle; at 1 → `RESP`.
- `RESP`: `mem_ready=1` and `mem_rdata=` array word for the latched index.
  - If `mem_valid=1`, a new request is accepted in the same cycle (back-to-back).
  - Otherwise → `IDLE`.
- Address handling: `mem_addr[1:0]` is ignored (word-aligned fetch). Bits above the index alias (wrap modulo DEPTH words).
- Writes: see Configuration. A write response pulses `mem_ready` with `mem_rdata=0`.
- `mem_rdata` is 0 whenever `mem_ready=0`.

## Timing
- Reset values: `mem_ready=0`, `mem_rdata=0`, counter 0, state `IDLE`.
- Latency: accept in cycle t → `mem_ready` in cycle t+1+LATENCY, exactly one cycle wide.
- Throughput: one response per 1+LATENCY cycles with continuous `mem_valid`. With LATENCY=0, the block gives one response per cycle.
- Write commit: the array is written in the accept cycle, so a read accepted in the next slot returns the new data.
- Reset mid-operation (`rst=1` in `WAIT` or `RESP`):
  - The pending response is dropped.
  - `mem_ready=0` from the next cycle.
  - The array contents are not cleared.
  - A write already committed stays.
- Address change during `WAIT`: no effect; the latched index is served.
- Simultaneous `rst=1` and `mem_valid=1`: reset wins; nothing is accepted and no write occurs.

## Configuration
- `IMEM_WRITE_EN` defined:
  - A request with `mem_instr=0` and `mem_wstrb≠0` writes `wdata` bytes where the strobe is 1.
  - `mem_instr=1` is always a read, regardless of `mem_wstrb`.
- `IMEM_WRITE_EN` undefined:
  - Read-only ROM behaviour. `mem_wstrb` and `mem_wdata` are ignored; every request is a read returning the array word.
  - The array write port is removed.
- Contents are loaded at elaboration via `$readmemh` from the package constant `imem_init_file`, in both configurations.

## Structure
- Shared package (`constants`): `imem_resp_state_type` enum (`IDLE`/`WAIT`/`RESP`) and `imem_init_file`. The `imem_responder` register record type and its `init_imem_responder_reg` reset value go in `wires`.
- `mem_in_type`/`mem_out_type` already exist in `wires` and are reused unchanged.
- One sub-module, `imem_ram`: DEPTH×32 array, single port, byte write enables, asynchronous-index read of the latched address. The responder owns only the FSM, counter and latches.

## Test plan
- Read, LATENCY=1: init word[5]=0x00500093; request addr 0x14 in cycle 10 → `mem_ready=1` and `mem_rdata=0x00500093` in cycle 12 only; `mem_rdata=0` in cycles 11 and 13.
- Back-to-back, LATENCY=0: continuous `mem_valid`, addresses 0x0, 0x4, 0x8 → `mem_ready` high 3 consecutive cycles with words 0, 1, 2 in order.
- Aliasing, DEPTH=16: read addr 0x40 → word[0]; addr 0x43 → word[0].
- Write, with `IMEM_WRITE_EN`:
  - Write `mem_instr=0`, wstrb=4'b0011, wdata=0xAABBCCDD to 0x8 over old 0x11223344 → ready pulse with rdata 0.
  - Following read of 0x8 → 0x1122CCDD.
  - Without the macro, the same sequence reads 0x11223344.
- Reset in `WAIT`, LATENCY=3: accept in cycle 0, `rst=1` in cycle 2 → no `mem_ready` in cycle 4; outputs 0 until the next accept.
- Ignored-in-WAIT, LATENCY=2: addr 0x0 accepted, addr 0x4 presented during `WAIT` → response carries word[0]. A new request is accepted only in `RESP`.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared types, reset record and boot image for imem_responder
package imem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_resp_state_type;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic [31:0] mem_rdata;
      logic        mem_ready;
   } mem_out_type;

   typedef struct packed {
      imem_resp_state_type state;
      logic [3:0]          cnt;
      logic                wr;
   } imem_responder_reg_type;

   localparam imem_responder_reg_type init_imem_responder_reg = '{
      state: IDLE,
      cnt:   4'd0,
      wr:    1'b0
   };

   // Power-up image: word i holds "addi x1, x0, i" so every word is distinct and decodable.
   function automatic logic [31:0] imem_boot_word(input int i);
      logic [31:0] w;
      w = 32'(i);
      return (w << 20) | 32'h0000_0093;
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch-side request/response bundle with master/slave views
interface imem_responder_if;
   import imem_responder_pkg::*;

   mem_in_type  imem_in;
   mem_out_type imem_out;

   modport master (output imem_in, input imem_out);
   modport slave  (input imem_in, output imem_out);

endinterface

// File: rtl/imem_responder_ram.sv
// rtl/imem_responder_ram.sv - DEPTH x 32 word array, async read of latched index
// IMEM_WRITE_EN adds the byte-enabled write port; without it the array is a ROM.
module imem_ram
   import imem_responder_pkg::*;
#(
   parameter int DEPTH = 4096
) (
`ifdef IMEM_WRITE_EN
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   widx_i,
   input  logic [3:0]                 wstrb_i,
   input  logic [31:0]                wdata_i,
`endif
   input  logic [$clog2(DEPTH)-1:0]   ridx_i,
   output logic [31:0]                rdata_o
);

   typedef logic [31:0] word_arr_t [DEPTH];

   function automatic word_arr_t boot_image();
      word_arr_t img;
      for (int i = 0; i < DEPTH; i++) begin
         img[i] = imem_boot_word(i);
      end
      return img;
   endfunction

   word_arr_t mem_q = boot_image();

`ifdef IMEM_WRITE_EN
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) begin
               mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end
`endif

   assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder: accept, fixed wait, one-cycle response
// IMEM_WRITE_EN enables data-side writes (mem_instr=0 with nonzero strobes).
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst,
   imem_responder_if.slave    imem
);

   localparam int         IW      = $clog2(DEPTH);
   localparam logic [3:0] LAT_CNT = 4'(LATENCY);

   imem_responder_reg_type r_q, r_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [IW-1:0]          req_idx;
   logic                   req_wr;
   logic                   accept;
   logic [31:0]            ram_rdata;

   assign req_idx = imem.imem_in.mem_addr[IW+1:2];

`ifdef IMEM_WRITE_EN
   logic ram_we;
   logic unused_addr;

   assign req_wr      = !imem.imem_in.mem_instr && (imem.imem_in.mem_wstrb != 4'b0000);
   assign ram_we      = accept && req_wr && !rst;
   assign unused_addr = ^{imem.imem_in.mem_addr[31:IW+2], imem.imem_in.mem_addr[1:0]};
`else
   logic unused_in;

   assign req_wr    = 1'b0;
   assign unused_in = ^{imem.imem_in.mem_instr, imem.imem_in.mem_wdata, imem.imem_in.mem_wstrb,
                        imem.imem_in.mem_addr[31:IW+2], imem.imem_in.mem_addr[1:0]};
`endif

   always_comb begin
      r_d    = r_q;
      idx_d  = idx_q;
      accept = 1'b0;

      case (r_q.state)
         WAIT: begin
            r_d.cnt = r_q.cnt - 4'd1;
            if (r_q.cnt == 4'd1) begin
               r_d.state = RESP;
            end
         end
         RESP:    r_d.state = IDLE;
         default: ;
      endcase

      // A request in RESP overrides the return to IDLE, giving back-to-back service.
      if (r_q.state != WAIT && imem.imem_in.mem_valid) begin
         accept    = 1'b1;
         idx_d     = req_idx;
         r_d.wr    = req_wr;
         r_d.cnt   = LAT_CNT;
         r_d.state = (LATENCY == 0) ? RESP : WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= init_imem_responder_reg;
      end else begin
         r_q   <= r_d;
         idx_q <= idx_d;
      end
   end

   imem_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
`ifdef IMEM_WRITE_EN
      .clk_i   (clk),
      .we_i    (ram_we),
      .widx_i  (req_idx),
      .wstrb_i (imem.imem_in.mem_wstrb),
      .wdata_i (imem.imem_in.mem_wdata),
`endif
      .ridx_i  (idx_q),
      .rdata_o (ram_rdata)
   );

   assign imem.imem_out = '{
      mem_rdata: (r_q.state == RESP && !r_q.wr) ? ram_rdata : 32'h0,
      mem_ready: (r_q.state == RESP)
   };

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - three responder configurations driven in parallel against a response-schedule model
module tb_imem_responder;
   import imem_responder_pkg::*;

   localparam int NDUT = 3;

   function automatic int lat_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 1;
   endfunction

   function automatic int dep_of(input int k);
      return (k == 0) ? 16 : (k == 1) ? 64 : 4096;
   endfunction

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   mem_in_type  drv;
   logic        rdy  [NDUT];
   logic [31:0] rdat [NDUT];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      imem_responder_if bus ();
      assign bus.imem_in = drv;
      assign rdy[k]      = bus.imem_out.mem_ready;
      assign rdat[k]     = bus.imem_out.mem_rdata;

      imem_responder #(
         .DEPTH   (dep_of(k)),
         .LATENCY (lat_of(k))
      ) dut (
         .clk  (clk),
         .rst  (rst),
         .imem (bus)
      );
   end

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          nready = 0;
   bit          pend [NDUT];
   int          due  [NDUT];
   logic [31:0] dat  [NDUT];
   logic [31:0] mm   [NDUT][4096];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference: an accepted request is answered exactly 1+LATENCY cycles later; a new one is
   // taken only when nothing is outstanding or the outstanding answer is due this cycle.
   task automatic model_step(input int k, input bit resp_now);
      logic [31:0] wa;
      int          idx;
      bit          wr;
      if (rst) begin
         pend[k] = 1'b0;
      end else if (drv.mem_valid && (!pend[k] || resp_now)) begin
         wa  = (drv.mem_addr >> 2) % 32'(dep_of(k));
         idx = int'(wa);
`ifdef IMEM_WRITE_EN
         wr = !drv.mem_instr && (drv.mem_wstrb != 4'b0000);
`else
         wr = 1'b0;
`endif
         if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (drv.mem_wstrb[b]) mm[k][idx][8*b +: 8] = drv.mem_wdata[8*b +: 8];
            end
            dat[k] = 32'h0;
         end else begin
            dat[k] = mm[k][idx];
         end
         pend[k] = 1'b1;
         due[k]  = cyc + 1 + lat_of(k);
      end else if (resp_now) begin
         pend[k] = 1'b0;
      end
   endtask

   task automatic tick();
      bit er;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         er = pend[k] && (due[k] == cyc);
         check_eq($sformatf("d%0d_ready@%0d", k, cyc), 32'(rdy[k]), 32'(er));
         check_eq($sformatf("d%0d_rdata@%0d", k, cyc), rdat[k], er ? dat[k] : 32'h0);
         if (rdy[k]) nready++;
         model_step(k, er);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic req(input logic [31:0] a, input bit ins, input logic [3:0] s,
                      input logic [31:0] w, input int n);
      drv.mem_valid = 1'b1;
      drv.mem_instr = ins;
      drv.mem_addr  = a;
      drv.mem_wstrb = s;
      drv.mem_wdata = w;
      repeat (n) tick();
   endtask

   task automatic idle(input int n);
      drv.mem_valid = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      drv = '0;
      for (int k = 0; k < NDUT; k++) begin
         pend[k] = 1'b0;
         due[k]  = 0;
         dat[k]  = 32'h0;
         for (int i = 0; i < dep_of(k); i++) mm[k][i] = (32'(i) << 20) | 32'h0000_0093;
      end
      @(posedge clk);
      #1;
      repeat (3) tick();
      rst = 1'b0;

      req(32'h14, 1'b1, 4'h0, 32'h0, 1);
      idle(6);
      req(32'h40, 1'b1, 4'h0, 32'h0, 5);
      req(32'h43, 1'b1, 4'h0, 32'h0, 5);
      req(32'h08, 1'b0, 4'hF, 32'h1122_3344, 5);
      req(32'h08, 1'b0, 4'h3, 32'hAABB_CCDD, 5);
      req(32'h08, 1'b1, 4'h0, 32'h0, 5);
      req(32'h00, 1'b1, 4'h0, 32'h0, 1);
      req(32'h04, 1'b1, 4'h0, 32'h0, 1);
      req(32'h08, 1'b1, 4'h0, 32'h0, 1);
      idle(6);
      req(32'h00, 1'b1, 4'h0, 32'h0, 1);
      req(32'h04, 1'b1, 4'h0, 32'h0, 1);
      idle(1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(6);

      repeat (3000) begin
         if ($urandom_range(0, 99) < 30) begin
            drv.mem_valid = ($urandom_range(0, 9) < 8);
            drv.mem_instr = 1'($urandom_range(0, 1));
            drv.mem_addr  = $urandom;
            drv.mem_wdata = $urandom;
            drv.mem_wstrb = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 99) < 3);
         tick();
      end
      rst = 1'b0;
      idle(6);

      check_eq("ready_pulses_seen", 32'(nready > 100), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
